instruction_fifo_assembler: RTL and testbench
=============================================

// Module: instruction_fifo_assembler
// PURPOSE
//   Parametrised successor to the byte-serial instruction capture stage of the VGA GPU front end.
//   Assembles one opcode byte plus 0..MAX_ARGS argument bytes into a wide instruction word.
//   Queues committed instructions in a DEPTH-entry FIFO with valid/ready hand-off to the command decoder.
//   Byte capture continues while the decoder is stalled; only a commit needs FIFO space.
// PARAMETERS
//   BYTE_W    8   width of one host byte
//   MAX_ARGS  3   max argument bytes per instruction; INSTR_W = BYTE_W*(1+MAX_ARGS)
//   DEPTH     4   FIFO entries, power of two, >=2
// PORTS
//   i_clk          in   1                    single clock; all logic on rising edge
//   i_reset        in   1                    synchronous, active-high reset
//   i_data         in   BYTE_W               host byte
//   i_we           in   1                    byte strobe; i_data valid this cycle
//   i_commit       in   1                    end-of-instruction strobe
//   o_ack          out  1                    one-cycle pulse, cycle after each accepted byte
//   o_instruction  out  INSTR_W              FIFO head word; 0 when !o_valid
//   o_arg_count    out  $clog2(MAX_ARGS+1)   arg bytes in head word; 0 when !o_valid
//   o_valid        out  1                    FIFO non-empty
//   i_ready        in   1                    decoder accepts head; pop = o_valid & i_ready
//   o_full         out  1                    FIFO holds DEPTH entries
//   o_level        out  $clog2(DEPTH+1)      FIFO occupancy
//   o_err_overflow out  1                    sticky: arg byte beyond MAX_ARGS seen
//   o_err_drop     out  1                    sticky: commit lost to full FIFO
//   i_err_clear    in   1                    clears both sticky flags
// BEHAVIOUR
//   Reset: every output 0; assembler word 0; FSM in OPCODE; FIFO empty.
//   FSM OPCODE: i_we stores i_data in word[BYTE_W-1:0], clears the rest, sets argc=0, goes to ARGS.
//   FSM ARGS: i_we with argc<MAX_ARGS writes byte k=argc at word[BYTE_W*(k+1)+:BYTE_W], argc++.
//   ARGS, argc==MAX_ARGS: i_we drops the byte and sets o_err_overflow. o_ack still pulses.
//   o_ack: registered; high exactly one cycle after every cycle with i_we=1 (reset forces 0).
//   Commit in ARGS: push {word, argc}; FSM -> OPCODE. Commit in OPCODE: ignored, no push.
//   Same-cycle i_we & i_commit: byte is merged first, then the updated word is pushed.
//   Same-cycle opcode byte & commit in OPCODE: pushes the opcode with argc=0.
//   Push while full with no same-cycle pop: instruction discarded, o_err_drop set, FSM -> OPCODE.
//   Push while full with same-cycle pop: accepted; level unchanged.
//   Simultaneous push and pop at a non-full level: level unchanged.
//   Latency: commit in cycle N with FIFO empty -> o_valid=1 and word visible in cycle N+1.
//   FIFO: registered storage, wrapping read/write pointers mod DEPTH; o_full, o_valid and o_level are registered.
//   Pop when !o_valid: no effect.
//   i_err_clear has priority over the set condition in the same cycle; it does not touch the FIFO.
//   Reset mid-instruction: partial word, queued entries and flags are discarded.
// CONFIGURATION
//   INSTR_FIFO_ERR_EN defined: o_err_overflow / o_err_drop behave as above.
//   INSTR_FIFO_ERR_EN undefined: both ports tied 0, i_err_clear ignored.
//     Overflow bytes and full-FIFO commits are still dropped silently.
// TESTING
//   Send 0x12, 0xAA, 0xBB, then commit -> next cycle o_valid=1, o_instruction=0x00BBAA12, o_arg_count=2.
//   Pulse i_we with 0x05 together with i_commit in OPCODE -> o_instruction=0x00000005, o_arg_count=0.
//   Send 5 bytes 0x01..0x05 (MAX_ARGS=3), then commit -> word 0x04030201, argc=3, o_err_overflow=1.
//     Each of the 5 bytes gets an o_ack pulse.
//   Hold i_ready=0 and commit 5 instructions -> first 4 queued, o_full=1, 5th dropped, o_err_drop=1.
//     Then pop all -> FIFO order preserved.
//   With FIFO full, commit in the same cycle as a pop -> o_level stays 4, new word reaches head last.
//   Assert i_reset after 2 bytes and 2 queued entries -> next cycle o_valid=0, o_level=0, o_ack=0.
//     A fresh byte after reset is treated as an opcode.

Source files
------------

// File: rtl/instruction_fifo_assembler.sv
// Byte-serial instruction assembler feeding a DEPTH-entry valid/ready FIFO.
// Optional sticky error flags are enabled by defining INSTR_FIFO_ERR_EN.
module instruction_fifo_assembler #(
    parameter int unsigned BYTE_W   = 8,
    parameter int unsigned MAX_ARGS = 3,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic [BYTE_W-1:0]                    i_data,
    input  logic                                 i_we,
    input  logic                                 i_commit,
    output logic                                 o_ack,
    output logic [BYTE_W*(1+MAX_ARGS)-1:0]       o_instruction,
    output logic [$clog2(MAX_ARGS+1)-1:0]        o_arg_count,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic                                 o_full,
    output logic [$clog2(DEPTH+1)-1:0]           o_level,
    output logic                                 o_err_overflow,
    output logic                                 o_err_drop,
    input  logic                                 i_err_clear
);

    localparam int unsigned INSTR_W = BYTE_W * (1 + MAX_ARGS);
    localparam int unsigned ARGC_W  = $clog2(MAX_ARGS + 1);
    localparam int unsigned LVL_W   = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W   = $clog2(DEPTH);

    typedef enum logic {
        ST_OPCODE = 1'b0,
        ST_ARGS   = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   word_q, word_d;
    logic [ARGC_W-1:0]    argc_q, argc_d;
    logic                 push;
    logic                 overflow_set;

    logic [INSTR_W-1:0]   mem_word [DEPTH];
    logic [ARGC_W-1:0]    mem_argc [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]     level_d;
    logic                 pop;
    logic                 push_ok;
    logic                 drop_set;
    logic [INSTR_W-1:0]   head_word_d;
    logic [ARGC_W-1:0]    head_argc_d;

    // Assembler FSM: byte merge happens before any same-cycle commit.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        argc_d       = argc_q;
        push         = 1'b0;
        overflow_set = 1'b0;
        case (state_q)
            ST_OPCODE: begin
                if (i_we) begin
                    word_d  = INSTR_W'(i_data);
                    argc_d  = '0;
                    state_d = ST_ARGS;
                end
                if (i_we && i_commit) begin
                    push    = 1'b1;
                    state_d = ST_OPCODE;
                end
            end
            ST_ARGS: begin
                if (i_we) begin
                    if (argc_q < ARGC_W'(MAX_ARGS)) begin
                        for (int unsigned k = 0; k < MAX_ARGS; k++) begin
                            if (argc_q == ARGC_W'(k)) begin
                                word_d[BYTE_W*(k+1) +: BYTE_W] = i_data;
                            end
                        end
                        argc_d = argc_q + ARGC_W'(1);
                    end else begin
                        overflow_set = 1'b1;
                    end
                end
                if (i_commit) begin
                    push    = 1'b1;
                    state_d = ST_OPCODE;
                end
            end
            default: state_d = ST_OPCODE;
        endcase
    end

    // FIFO bookkeeping; a full FIFO still accepts a push when the head pops.
    always_comb begin
        pop      = o_valid & i_ready;
        push_ok  = push & (~o_full | pop);
        drop_set = push & o_full & ~pop;
        level_d  = o_level + LVL_W'(push_ok) - LVL_W'(pop);
        rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        head_word_d = '0;
        head_argc_d = '0;
        if (level_d != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                head_word_d = word_d;
                head_argc_d = argc_d;
            end else begin
                head_word_d = mem_word[rd_ptr_d];
                head_argc_d = mem_argc[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_OPCODE;
            word_q        <= '0;
            argc_q        <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            o_level       <= '0;
            o_full        <= 1'b0;
            o_valid       <= 1'b0;
            o_instruction <= '0;
            o_arg_count   <= '0;
            o_ack         <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            argc_q        <= argc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            o_level       <= level_d;
            o_full        <= (level_d == LVL_W'(DEPTH));
            o_valid       <= (level_d != '0);
            o_instruction <= head_word_d;
            o_arg_count   <= head_argc_d;
            o_ack         <= i_we;
        end
    end

    // Storage needs no reset: the head output is gated by occupancy.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_word[wr_ptr_q] <= word_d;
            mem_argc[wr_ptr_q] <= argc_d;
        end
    end

`ifdef INSTR_FIFO_ERR_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_err_overflow <= 1'b0;
            o_err_drop     <= 1'b0;
        end else if (i_err_clear) begin
            o_err_overflow <= 1'b0;
            o_err_drop     <= 1'b0;
        end else begin
            o_err_overflow <= o_err_overflow | overflow_set;
            o_err_drop     <= o_err_drop | drop_set;
        end
    end
`else
    logic unused_err;
    assign unused_err     = &{1'b0, i_err_clear, overflow_set, drop_set};
    assign o_err_overflow = 1'b0;
    assign o_err_drop     = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fifo_assembler.sv
// Directed bench for instruction_fifo_assembler with default parameters.
// Error-flag expectations follow INSTR_FIFO_ERR_EN.
module tb_instruction_fifo_assembler;

`ifdef INSTR_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_data;
    logic        i_we;
    logic        i_commit;
    logic        o_ack;
    logic [31:0] o_instruction;
    logic [1:0]  o_arg_count;
    logic        o_valid;
    logic        i_ready;
    logic        o_full;
    logic [2:0]  o_level;
    logic        o_err_overflow;
    logic        o_err_drop;
    logic        i_err_clear;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fifo_assembler dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_data         (i_data),
        .i_we           (i_we),
        .i_commit       (i_commit),
        .o_ack          (o_ack),
        .o_instruction  (o_instruction),
        .o_arg_count    (o_arg_count),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_full         (o_full),
        .o_level        (o_level),
        .o_err_overflow (o_err_overflow),
        .o_err_drop     (o_err_drop),
        .i_err_clear    (i_err_clear)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_data = b;
        i_we   = 1'b1;
        step();
        i_we   = 1'b0;
    endtask

    task automatic push_opcode(input logic [7:0] b);
        i_data   = b;
        i_we     = 1'b1;
        i_commit = 1'b1;
        step();
        i_we     = 1'b0;
        i_commit = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
        checks++;
        if ({o_ack, o_valid, o_full, o_err_overflow, o_err_drop} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 00000", {o_ack, o_valid, o_full, o_err_overflow, o_err_drop});
        end
        checks++;
        if ({o_instruction, o_arg_count, o_level} !== 37'h0) begin
            errors++;
            $display("FAIL reset_data: got instr=%h argc=%0d level=%0d exp all 0", o_instruction, o_arg_count, o_level);
        end
    endtask

    task automatic test_basic();
        logic [7:0] bytes [3];
        bytes[0] = 8'h12; bytes[1] = 8'hAA; bytes[2] = 8'hBB;
        for (int i = 0; i < 3; i++) begin
            send_byte(bytes[i]);
            checks++;
            if (o_ack !== 1'b1) begin
                errors++;
                $display("FAIL basic_ack[%0d]: got %b exp 1", i, o_ack);
            end
        end
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_precommit_valid: got %b exp 0", o_valid);
        end
        i_commit = 1'b1;
        step();
        i_commit = 1'b0;
        checks++;
        if ({o_valid, o_instruction, o_arg_count, o_level} !== {1'b1, 32'h00BBAA12, 2'd2, 3'd1}) begin
            errors++;
            $display("FAIL basic_word: got v=%b instr=%h argc=%0d lvl=%0d exp v=1 instr=00bbaa12 argc=2 lvl=1",
                     o_valid, o_instruction, o_arg_count, o_level);
        end
        checks++;
        if (o_ack !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack_idle: got %b exp 0", o_ack);
        end
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        checks++;
        if ({o_valid, o_instruction, o_level} !== 36'h0) begin
            errors++;
            $display("FAIL basic_pop: got v=%b instr=%h lvl=%0d exp 0", o_valid, o_instruction, o_level);
        end
    endtask

    task automatic test_opcode_commit();
        i_commit = 1'b1;
        i_ready  = 1'b1;
        step();
        i_commit = 1'b0;
        i_ready  = 1'b0;
        checks++;
        if ({o_valid, o_level} !== 4'h0) begin
            errors++;
            $display("FAIL bare_commit: got v=%b lvl=%0d exp 0", o_valid, o_level);
        end
        push_opcode(8'h05);
        checks++;
        if ({o_valid, o_instruction, o_arg_count} !== {1'b1, 32'h00000005, 2'd0}) begin
            errors++;
            $display("FAIL opcode_commit: got v=%b instr=%h argc=%0d exp v=1 instr=00000005 argc=0",
                     o_valid, o_instruction, o_arg_count);
        end
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i));
            checks++;
            if (o_ack !== 1'b1) begin
                errors++;
                $display("FAIL ovf_ack[%0d]: got %b exp 1", i, o_ack);
            end
        end
        i_commit = 1'b1;
        step();
        i_commit = 1'b0;
        checks++;
        if ({o_instruction, o_arg_count} !== {32'h04030201, 2'd3}) begin
            errors++;
            $display("FAIL ovf_word: got instr=%h argc=%0d exp instr=04030201 argc=3", o_instruction, o_arg_count);
        end
        checks++;
        if ({o_err_overflow, o_err_drop} !== {ERR_EN, 1'b0}) begin
            errors++;
            $display("FAIL ovf_flag: got ovf=%b drop=%b exp ovf=%b drop=0", o_err_overflow, o_err_drop, ERR_EN);
        end
        i_err_clear = 1'b1;
        i_ready     = 1'b1;
        step();
        i_err_clear = 1'b0;
        i_ready     = 1'b0;
        checks++;
        if ({o_err_overflow, o_valid} !== 2'b00) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%b v=%b exp 0 0", o_err_overflow, o_valid);
        end
    endtask

    task automatic test_full_drop();
        logic [31:0] exp_q [4];
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(8'h30 + i));
            i_data   = 8'(8'h40 + i);
            i_we     = 1'b1;
            i_commit = 1'b1;
            step();
            i_we     = 1'b0;
            i_commit = 1'b0;
            if (i < 4) exp_q[i] = {16'h0, 8'(8'h40 + i), 8'(8'h30 + i)};
        end
        checks++;
        if ({o_full, o_level, o_err_drop} !== {1'b1, 3'd4, ERR_EN}) begin
            errors++;
            $display("FAIL full_drop: got full=%b lvl=%0d drop=%b exp full=1 lvl=4 drop=%b",
                     o_full, o_level, o_err_drop, ERR_EN);
        end
        checks++;
        if ({o_instruction, o_arg_count} !== {32'h00004030, 2'd1}) begin
            errors++;
            $display("FAIL full_head: got instr=%h argc=%0d exp 00004030 argc=1", o_instruction, o_arg_count);
        end
        // Clear and drop in the same cycle: clear wins.
        send_byte(8'h3F);
        i_data      = 8'h4F;
        i_we        = 1'b1;
        i_commit    = 1'b1;
        i_err_clear = 1'b1;
        step();
        i_we        = 1'b0;
        i_commit    = 1'b0;
        i_err_clear = 1'b0;
        checks++;
        if ({o_err_drop, o_level} !== {1'b0, 3'd4}) begin
            errors++;
            $display("FAIL clear_priority: got drop=%b lvl=%0d exp drop=0 lvl=4", o_err_drop, o_level);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_instruction !== exp_q[i]) begin
                errors++;
                $display("FAIL drop_order[%0d]: got %h exp %h", i, o_instruction, exp_q[i]);
            end
            i_ready = 1'b1;
            step();
            i_ready = 1'b0;
        end
        checks++;
        if ({o_valid, o_full, o_level} !== 5'h0) begin
            errors++;
            $display("FAIL drop_empty: got v=%b full=%b lvl=%0d exp 0", o_valid, o_full, o_level);
        end
    endtask

    task automatic test_full_pop_push();
        logic [31:0] exp_q [4];
        exp_q[0] = 32'h51; exp_q[1] = 32'h52; exp_q[2] = 32'h53; exp_q[3] = 32'h99;
        for (int i = 0; i < 4; i++) push_opcode(8'(8'h50 + i));
        i_data   = 8'h99;
        i_we     = 1'b1;
        i_commit = 1'b1;
        i_ready  = 1'b1;
        step();
        i_we     = 1'b0;
        i_commit = 1'b0;
        i_ready  = 1'b0;
        checks++;
        if ({o_full, o_level, o_err_drop} !== {1'b1, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL fullpp_level: got full=%b lvl=%0d drop=%b exp full=1 lvl=4 drop=0", o_full, o_level, o_err_drop);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_instruction !== exp_q[i]) begin
                errors++;
                $display("FAIL fullpp_order[%0d]: got %h exp %h", i, o_instruction, exp_q[i]);
            end
            i_ready = 1'b1;
            step();
            i_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        push_opcode(8'h61);
        i_data   = 8'h62;
        i_we     = 1'b1;
        i_commit = 1'b1;
        i_ready  = 1'b1;
        step();
        i_we     = 1'b0;
        i_commit = 1'b0;
        i_ready  = 1'b0;
        checks++;
        if ({o_level, o_instruction} !== {3'd1, 32'h62}) begin
            errors++;
            $display("FAIL b2b_pushpop: got lvl=%0d instr=%h exp lvl=1 instr=00000062", o_level, o_instruction);
        end
        i_ready = 1'b1;
        step();
        step();
        i_ready = 1'b0;
        checks++;
        if ({o_valid, o_level} !== 4'h0) begin
            errors++;
            $display("FAIL b2b_empty_pop: got v=%b lvl=%0d exp 0", o_valid, o_level);
        end
    endtask

    task automatic test_reset_mid();
        push_opcode(8'h71);
        push_opcode(8'h72);
        send_byte(8'h77);
        send_byte(8'h88);
        i_data  = 8'h99;
        i_we    = 1'b1;
        i_reset = 1'b1;
        step();
        i_we    = 1'b0;
        i_reset = 1'b0;
        checks++;
        if ({o_valid, o_level, o_ack, o_instruction} !== 37'h0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b lvl=%0d ack=%b instr=%h exp 0", o_valid, o_level, o_ack, o_instruction);
        end
        push_opcode(8'h21);
        checks++;
        if ({o_instruction, o_arg_count} !== {32'h00000021, 2'd0}) begin
            errors++;
            $display("FAIL post_reset_opcode: got instr=%h argc=%0d exp 00000021 argc=0", o_instruction, o_arg_count);
        end
    endtask

    initial begin
        i_reset     = 1'b1;
        i_data      = '0;
        i_we        = 1'b0;
        i_commit    = 1'b0;
        i_ready     = 1'b0;
        i_err_clear = 1'b0;
        test_reset();
        test_basic();
        test_opcode_commit();
        test_overflow();
        test_full_drop();
        test_full_pop_push();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
